// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - shared defaults, count-width helper and output state type for io_port_fifo
package io_port_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } out_state_t;

    // Occupancy must represent 0..depth inclusive, hence one bit more than the pointer.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - show-ahead circular input buffer with registered count/full/empty
module io_fifo
    import io_port_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         wr_data,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_d;
    logic              push_ok;
    logic              pop_ok;

    // Gating uses only registered flags, so a full buffer refuses a push even when a pop is in flight.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_d = count;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    // Storage is cleared too so the head reads zero out of reset.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_d;
            full  <= (count_d == CNT_W'(DEPTH));
            empty <= (count_d == '0);
        end
    end

endmodule

// File: rtl/io_port_fifo.sv
// rtl/io_port_fifo.sv - CPU I/O port: handshaked output register plus buffered input FIFO (irq via IO_PORT_IRQ_EN)
module io_port_fifo
    import io_port_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      out_wr,
    input  logic [DATA_W-1:0]         bus_d,
    output logic [DATA_W-1:0]         out_q,
    output logic                      out_valid,
    input  logic                      out_ack,
    input  logic [DATA_W-1:0]         ext_d,
    input  logic                      ext_valid,
    output logic                      ext_ready,
    input  logic                      in_rd,
    output logic [DATA_W-1:0]         in_q,
    output logic                      in_empty,
    output logic                      in_full,
    output logic [cnt_w(DEPTH)-1:0]   in_count,
    output logic                      overrun,
    input  logic                      ovr_clr
`ifdef IO_PORT_IRQ_EN
    ,
    output logic                      irq
`endif
);

    out_state_t state_q;
    out_state_t state_d;
    logic       load_out;
    logic       drop;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A new write always wins over a concurrent ack: the device must see the latest value.
    always_comb begin
        state_d  = state_q;
        load_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (out_wr) begin
                    load_out = 1'b1;
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                if (out_wr) begin
                    load_out = 1'b1;
                end else if (out_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            out_q <= '0;
        end else if (load_out) begin
            out_q <= bus_d;
        end
    end

    assign out_valid = (state_q == PENDING);

    io_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .clear   (clear),
        .push    (ext_valid),
        .pop     (in_rd),
        .wr_data (ext_d),
        .rd_data (in_q),
        .full    (in_full),
        .empty   (in_empty),
        .count   (in_count)
    );

    assign ext_ready = ~in_full;
    assign drop      = ext_valid & in_full;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef IO_PORT_IRQ_EN
    logic ack_done;

    // Completion is the PENDING->IDLE transition taken on this edge, giving a one-cycle pulse.
    assign ack_done = (state_q == PENDING) && (state_d == IDLE);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            irq <= 1'b0;
        end else begin
            irq <= ~in_empty | overrun | ack_done;
        end
    end
`endif

endmodule

// File: tb/tb_io_port_fifo.sv
// tb/tb_io_port_fifo.sv - directed self-checking bench for io_port_fifo
module tb_io_port_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clock = 1'b0;
    logic              clear;
    logic              out_wr;
    logic [DATA_W-1:0] bus_d;
    logic [DATA_W-1:0] out_q;
    logic              out_valid;
    logic              out_ack;
    logic [DATA_W-1:0] ext_d;
    logic              ext_valid;
    logic              ext_ready;
    logic              in_rd;
    logic [DATA_W-1:0] in_q;
    logic              in_empty;
    logic              in_full;
    logic [2:0]        in_count;
    logic              overrun;
    logic              ovr_clr;
`ifdef IO_PORT_IRQ_EN
    logic              irq;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int q[$];
    logic [31:0] exp_rd [4];

    io_port_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .out_wr    (out_wr),
        .bus_d     (bus_d),
        .out_q     (out_q),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .ext_d     (ext_d),
        .ext_valid (ext_valid),
        .ext_ready (ext_ready),
        .in_rd     (in_rd),
        .in_q      (in_q),
        .in_empty  (in_empty),
        .in_full   (in_full),
        .in_count  (in_count),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
`ifdef IO_PORT_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_q"},     out_q, 32'h0);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
        chk({tag, "_in_empty"},  {31'b0, in_empty}, 32'h1);
        chk({tag, "_in_full"},   {31'b0, in_full}, 32'h0);
        chk({tag, "_ext_ready"}, {31'b0, ext_ready}, 32'h1);
        chk({tag, "_in_count"},  {29'b0, in_count}, 32'h0);
        chk({tag, "_in_q"},      in_q, 32'h0);
        chk({tag, "_overrun"},   {31'b0, overrun}, 32'h0);
`ifdef IO_PORT_IRQ_EN
        chk({tag, "_irq"},       {31'b0, irq}, 32'h0);
`endif
    endtask

    initial begin
        clear = 1'b1; out_wr = 0; bus_d = '0; out_ack = 0;
        ext_d = '0; ext_valid = 0; in_rd = 0; ovr_clr = 0;
        step(); step();
        chk_reset_state("rst");
        clear = 1'b0;
        step();

        // Output handshake
        out_wr = 1; bus_d = 32'hDEADBEEF; step(); out_wr = 0;
        chk("wr_out_q", out_q, 32'hDEADBEEF);
        chk("wr_valid", {31'b0, out_valid}, 32'h1);
        out_ack = 1; step();
        chk("ack_valid", {31'b0, out_valid}, 32'h0);
        chk("ack_hold", out_q, 32'hDEADBEEF);
        step();
        chk("idle_ack_ign", {31'b0, out_valid}, 32'h0);
        out_ack = 0; out_wr = 1; bus_d = 32'h5; step();
        out_ack = 1; bus_d = 32'h1; step();
        out_wr = 0; out_ack = 0;
        chk("wr_ack_q", out_q, 32'h1);
        chk("wr_ack_valid", {31'b0, out_valid}, 32'h1);
        step();
        chk("pend_hold", {31'b0, out_valid}, 32'h1);

        // Fill
        ext_valid = 1;
        for (int i = 0; i < 4; i++) begin
            ext_d = 32'hA + i;
            step();
            chk("fill_cnt", {29'b0, in_count}, i + 1);
            chk("fill_head", in_q, 32'hA);
        end
        ext_valid = 0;
        chk("fill_full", {31'b0, in_full}, 32'h1);
        chk("fill_ready", {31'b0, ext_ready}, 32'h0);
        chk("fill_empty", {31'b0, in_empty}, 32'h0);

        // Drain with one extra pop on empty
        in_rd = 1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) chk("drain_data", in_q, 32'hA + i);
            step();
            chk("drain_cnt", {29'b0, in_count}, (i < 4) ? 3 - i : 0);
        end
        in_rd = 0;
        chk("drain_empty", {31'b0, in_empty}, 32'h1);
        chk("drain_full", {31'b0, in_full}, 32'h0);

        // Overrun: dropped push while popping a full buffer
        ext_valid = 1;
        for (int i = 0; i < 4; i++) begin
            ext_d = 32'h10 + i;
            step();
        end
        ext_d = 32'hE; in_rd = 1; step();
        in_rd = 0;
        chk("ovr_flag", {31'b0, overrun}, 32'h1);
        chk("ovr_cnt", {29'b0, in_count}, 32'h3);
        chk("ovr_head", in_q, 32'h11);
        ext_d = 32'h14; step();
        chk("ovr_refill", {29'b0, in_count}, 32'h4);
        ovr_clr = 1; step();
        chk("ovr_setwins", {31'b0, overrun}, 32'h1);
        ext_valid = 0; step();
        ovr_clr = 0;
        chk("ovr_cleared", {31'b0, overrun}, 32'h0);
        exp_rd = '{32'h11, 32'h12, 32'h13, 32'h14};
        in_rd = 1;
        for (int i = 0; i < 4; i++) begin
            chk("ovr_data", in_q, exp_rd[i]);
            step();
        end
        in_rd = 0;
        chk("ovr_drained", {31'b0, in_empty}, 32'h1);

        // Push and pop together on empty: push only
        ext_valid = 1; in_rd = 1; ext_d = 32'h77; step();
        ext_valid = 0; in_rd = 0;
        chk("emp_pp_cnt", {29'b0, in_count}, 32'h1);
        chk("emp_pp_head", in_q, 32'h77);
        in_rd = 1; step(); in_rd = 0;
        q.delete();

        // Wrap-around with a queue model
        for (int i = 0; i < 10; i++) begin
            bit do_push;
            bit do_pop;
            ext_valid = 1; ext_d = 32'h100 + i; in_rd = (i % 3 == 2);
            if (q.size() > 0) chk("wrap_head", in_q, q[0]);
            do_push = q.size() < DEPTH;
            do_pop  = in_rd && (q.size() > 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(32'h100 + i);
            step();
            chk("wrap_cnt", {29'b0, in_count}, q.size());
        end
        ext_valid = 0; in_rd = 1;
        while (q.size() > 0) begin
            chk("wrap_drain", in_q, q[0]);
            void'(q.pop_front());
            step();
        end
        in_rd = 0;
        chk("wrap_empty", {31'b0, in_empty}, 32'h1);
        chk("wrap_ovr", {31'b0, overrun}, 32'h1);

        // Asynchronous clear mid-cycle with data pending on both sides
        ext_valid = 1; ext_d = 32'h55; out_wr = 1; bus_d = 32'h99; step();
        ext_valid = 0; out_wr = 0;
        #3 clear = 1;
        #1 chk_reset_state("aclr");
        step();
        clear = 0;
        step();

`ifdef IO_PORT_IRQ_EN
        ext_valid = 1; ext_d = 32'h3; step(); ext_valid = 0;
        chk("irq_lag", {31'b0, irq}, 32'h0);
        step();
        chk("irq_push", {31'b0, irq}, 32'h1);
        in_rd = 1; step(); in_rd = 0;
        step();
        chk("irq_empty", {31'b0, irq}, 32'h0);
        out_wr = 1; bus_d = 32'h4; step(); out_wr = 0;
        out_ack = 1; step(); out_ack = 0;
        chk("irq_ack", {31'b0, irq}, 32'h1);
        step();
        chk("irq_pulse_end", {31'b0, irq}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/io_port_fifo.md
# io_port_fifo

Parametrised CPU I/O port pairing a handshaked output register with a buffered input FIFO; successor to the single-register in/out ports. Sits between the datapath bus (BusMux in, MDR/Y load strobes out) and an external device, decoupling device timing from instruction timing. Adds valid/ack output handshake, configurable-depth input buffering, status flags and sticky overrun detection.

## Interface
- DATA_W, 32, width of both data paths
- DEPTH, 4, input FIFO entries; power of two, ≥2
- clock  in  1  rising-edge clock, single domain
- clear  in  1  asynchronous, active-high reset
- out_wr  in  1  CPU write strobe to output register
- bus_d  in  DATA_W  CPU data for output register
- out_q  out  DATA_W  output register contents
- out_valid  out  1  output data pending for device
- out_ack  in  1  device accepts out_q
- ext_d  in  DATA_W  device data into FIFO
- ext_valid  in  1  device offers ext_d
- ext_ready  out  1  FIFO can accept (= !in_full)
- in_rd  in  1  CPU pop strobe
- in_q  out  DATA_W  FIFO head, show-ahead
- in_empty  out  1  FIFO empty
- in_full  out  1  FIFO full
- in_count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- overrun  out  1  sticky: device data dropped
- ovr_clr  in  1  clears overrun
- irq  out  1  interrupt request (only with IO_PORT_IRQ_EN)

## Operation
- Reset (clear=1, asynchronous): out_q=0, out_valid=0, FIFO pointers=0, in_count=0, in_empty=1, in_full=0, ext_ready=1, in_q=0, overrun=0, irq=0.
- Output side, two states IDLE (out_valid=0) / PENDING (out_valid=1):
  - IDLE + out_wr: out_q←bus_d, →PENDING.
  - PENDING + out_ack, no out_wr: →IDLE; out_q holds last value.
  - PENDING + out_wr (with or without out_ack): out_q←bus_d, stay PENDING (latest wins).
  - out_ack in IDLE: ignored.
- Input side, circular buffer with wrapping read/write pointers:
  - push = ext_valid & !in_full; pop = in_rd & !in_empty.
  - push only: write ext_d at wr_ptr, count+1. pop only: rd_ptr+1, count−1. Both: count unchanged.
  - Full: push refused even if in_rd same cycle (ext_ready combinational from registered full flag); ext_valid&in_full sets overrun.
  - Empty: in_rd ignored, count stays 0; push+in_rd on empty → push only, count=1.
  - Pointers wrap DEPTH−1→0; in_count never exceeds DEPTH nor underflows.
- overrun: set by dropped push, cleared by ovr_clr; set wins if both same cycle.

## Timing
- out_wr at edge N → out_q/out_valid updated after edge N; out_ack at edge M → out_valid low after M.
- Push at edge N → in_q shows data after N when previously empty; in_empty/in_count/in_full registered, update after the same edge.
- in_q is head entry (combinational read of registered array); changes after each pop edge.
- All flags registered; no combinational path from ext_valid to ext_ready or from in_rd to in_q.
- clear mid-transfer discards FIFO contents and pending output immediately.

## Configuration
- IO_PORT_IRQ_EN defined: irq port present; irq registered, = !in_empty | overrun | (out_valid fell this cycle, i.e. one-cycle pulse on ack completion); reset 0.
- Undefined: no irq port, no irq logic; all other behaviour identical.

## Structure
- io_port_pkg: DATA_W default, count-width helper function, output state enum (IDLE, PENDING).
- Sub-module io_fifo: storage array, pointers, count, full/empty; parameters DATA_W, DEPTH; io_port_fifo adds output FSM, overrun and irq.

## Test plan
- Reset: assert clear mid-cycle → all outputs zero, in_empty=1, ext_ready=1 without waiting for clock.
- Output handshake: out_wr bus_d=0xDEADBEEF → out_q=0xDEADBEEF, out_valid=1; out_ack → out_valid=0, out_q held; out_wr 0x1 with out_ack same cycle in PENDING → out_q=0x1, out_valid=1.
- FIFO fill/drain DEPTH=4: push 0xA,0xB,0xC,0xD → in_full=1, in_count=4; five in_rd → reads A,B,C,D, 5th ignored, in_count=0.
- Overrun: full FIFO, ext_valid with 0xE and in_rd same cycle → 0xE dropped, overrun=1, in_count=3; ovr_clr → overrun=0.
- Wrap-around: 10 interleaved push/pop of incrementing values → in-order data, count never >4, pointers wrap correctly.
- IRQ (macro on): single push → irq=1 next cycle; pop to empty → irq=0; out_ack completion → one-cycle irq pulse.
